// File: rtl/pll_pkg.sv
// Shared PLL types: lock detector states, nominal reference frequency, frequency word, |a-b| helper.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } lock_state_t;

  localparam int unsigned F0_HZ = 40000;

  typedef logic [31:0] freq_t;

  // Unsigned distance; the result always fits in 32 bits so no overflow handling is needed.
  function automatic freq_t abs_diff(input freq_t a, input freq_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/link_edge_sync.sv
// Two-flop synchronizer for the asynchronous link reference plus a registered rising-edge pulse.
module link_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_link,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_link;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2 & ~r_sync3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/freq_lock_detect.sv
// Lock detector beside the PLL core: qualifies frequency word f on each link reference edge.
// Build option FREQ_LOCK_AVG_EN: f_lock is the mean of the last four edge samples and tracks it while locked.
module freq_lock_detect
  import pll_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned TOL         = 16,
  parameter int unsigned UNLOCK_TOL  = 64,
  parameter int unsigned UNLOCK_CNT  = 2,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swiptAlive,
  input  logic        link,
  input  logic [31:0] f,
  output logic        freq_rdy,
  output logic [31:0] f_lock,
  output logic        link_lost,
  output logic [7:0]  lock_cnt,
  output logic [1:0]  state
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] LOCK_CNT_B   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_CNT_B = 8'(UNLOCK_CNT);

  lock_state_t      r_state;
  logic             r_freq_rdy;
  freq_t            r_f_lock;
  logic             r_link_lost;
  logic [7:0]       r_lock_cnt;
  logic [7:0]       r_miss;
  freq_t            r_f_prev;
  logic [TMO_W-1:0] r_tmo;

  logic       w_rise;
  freq_t      w_d_prev;
  freq_t      w_d_lock;
  logic [7:0] w_cnt_inc;
  logic [7:0] w_miss_inc;
  logic       w_tmo_active;
  logic       w_tmo_hit;
  freq_t      w_lock_val;

  link_edge_sync u_link_sync (
    .clk    (clk),
    .rst    (rst),
    .i_link (link),
    .o_rise (w_rise)
  );

`ifdef FREQ_LOCK_AVG_EN
  localparam bit AVG_EN = 1'b1;
  freq_t       r_hist0;
  freq_t       r_hist1;
  freq_t       r_hist2;
  logic [33:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist0 <= '0;
      r_hist1 <= '0;
      r_hist2 <= '0;
    end else if (w_rise) begin
      r_hist0 <= f;
      r_hist1 <= r_hist0;
      r_hist2 <= r_hist1;
    end
  end

  // Current sample plus the three previous edge samples.
  assign w_sum      = {2'b00, f} + {2'b00, r_hist0} + {2'b00, r_hist1} + {2'b00, r_hist2};
  assign w_lock_val = freq_t'(w_sum >> 2);
`else
  localparam bit AVG_EN = 1'b0;
  assign w_lock_val = f;
`endif

  assign w_d_prev     = abs_diff(f, r_f_prev);
  assign w_d_lock     = abs_diff(f, r_f_lock);
  assign w_cnt_inc    = (r_lock_cnt == 8'hFF) ? r_lock_cnt : r_lock_cnt + 8'd1;
  assign w_miss_inc   = (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;
  assign w_tmo_active = (r_state == ACQUIRE) || (r_state == LOCKED);
  assign w_tmo_hit    = (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst || !swiptAlive) begin
      r_state     <= IDLE;
      r_freq_rdy  <= 1'b0;
      r_f_lock    <= '0;
      r_link_lost <= 1'b0;
      r_lock_cnt  <= '0;
      r_miss      <= '0;
      r_tmo       <= '0;
      if (rst) r_f_prev <= '0;
    end else begin
      r_link_lost <= 1'b0;
      // A link edge in the same cycle as the timeout limit wins and restarts the count.
      if (w_tmo_active && !w_rise) begin
        if (w_tmo_hit) begin
          r_state     <= LOST;
          r_link_lost <= 1'b1;
          r_freq_rdy  <= 1'b0;
          r_lock_cnt  <= '0;
          r_miss      <= '0;
          r_tmo       <= '0;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end
      if (w_rise) begin
        r_tmo    <= '0;
        r_f_prev <= f;
        case (r_state)
          IDLE, LOST: begin
            r_state    <= ACQUIRE;
            r_lock_cnt <= '0;
          end
          ACQUIRE: begin
            if (w_d_prev <= TOL) begin
              r_lock_cnt <= w_cnt_inc;
              if (w_cnt_inc >= LOCK_CNT_B) begin
                r_state    <= LOCKED;
                r_freq_rdy <= 1'b1;
                r_f_lock   <= w_lock_val;
                r_miss     <= '0;
              end
            end else begin
              r_lock_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_d_lock > UNLOCK_TOL) begin
              r_lock_cnt <= '0;
              if (w_miss_inc >= UNLOCK_CNT_B) begin
                r_state    <= ACQUIRE;
                r_freq_rdy <= 1'b0;
                r_miss     <= '0;
              end else begin
                r_miss <= w_miss_inc;
              end
            end else begin
              r_miss     <= '0;
              r_lock_cnt <= w_cnt_inc;
              if (AVG_EN) r_f_lock <= w_lock_val;
            end
          end
        endcase
      end
    end
  end

  assign freq_rdy  = r_freq_rdy;
  assign f_lock    = r_f_lock;
  assign link_lost = r_link_lost;
  assign lock_cnt  = r_lock_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_freq_lock_detect.sv
// Randomized bench for freq_lock_detect: edge-level reference model feeds expected queues drained by monitors.
module tb_freq_lock_detect;
  import pll_pkg::*;

  localparam int unsigned LOCK_CNT    = 4;
  localparam int unsigned TOL         = 16;
  localparam int unsigned UNLOCK_TOL  = 64;
  localparam int unsigned UNLOCK_CNT  = 2;
  localparam int unsigned TIMEOUT_CYC = 5000;

  // Expected outputs just before (rdy_b, st_b) and just after one link edge takes effect.
  typedef struct packed {
    logic        rdy_b;
    lock_state_t st_b;
    logic        rdy;
    freq_t       flock;
    logic [7:0]  cnt;
    lock_state_t st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swiptAlive = 1'b1;
  logic       link = 1'b0;
  freq_t      f = '0;
  logic       freq_rdy;
  freq_t      f_lock;
  logic       link_lost;
  logic [7:0] lock_cnt;
  logic [1:0] state;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];
  int unsigned exp_lost_q[$];

  lock_state_t m_st;
  logic        m_rdy;
  freq_t       m_lock;
  freq_t       m_prev;
  int          m_cnt;
  int          m_miss;
  longint      m_hist[$];

  freq_lock_detect #(
    .LOCK_CNT    (LOCK_CNT),
    .TOL         (TOL),
    .UNLOCK_TOL  (UNLOCK_TOL),
    .UNLOCK_CNT  (UNLOCK_CNT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .swiptAlive (swiptAlive),
    .link       (link),
    .f          (f),
    .freq_rdy   (freq_rdy),
    .f_lock     (f_lock),
    .link_lost  (link_lost),
    .lock_cnt   (lock_cnt),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_freq_rdy"}, 32'(freq_rdy), 32'd0);
    check({tag, "_f_lock"}, f_lock, 32'd0);
    check({tag, "_link_lost"}, 32'(link_lost), 32'd0);
    check({tag, "_lock_cnt"}, 32'(lock_cnt), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
  endtask

  // ---------------- reference model ----------------
  function automatic longint absd(input freq_t a, input freq_t b);
    longint da;
    longint db;
    da = {32'd0, a};
    db = {32'd0, b};
    return (da > db) ? da - db : db - da;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_st   = IDLE;
    m_rdy  = 1'b0;
    m_lock = '0;
    m_prev = '0;
    m_cnt  = 0;
    m_miss = 0;
    m_hist = '{0, 0, 0, 0};
  endtask

  task automatic model_edge(input freq_t fval, input logic sw, input int gap);
    exp_t  e;
    freq_t lock_new;
    e.rdy_b = m_rdy;
    e.st_b  = m_st;
    m_hist.push_back({32'd0, fval});
    void'(m_hist.pop_front());
`ifdef FREQ_LOCK_AVG_EN
    lock_new = freq_t'((m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4);
`else
    lock_new = fval;
`endif
    if (!sw) begin
      m_st = IDLE; m_rdy = 1'b0; m_lock = '0; m_cnt = 0; m_miss = 0;
    end else begin
      case (m_st)
        IDLE, LOST: begin
          m_st = ACQUIRE; m_prev = fval; m_cnt = 0;
        end
        ACQUIRE: begin
          if (absd(fval, m_prev) <= TOL) begin
            m_cnt = sat255(m_cnt + 1);
            if (m_cnt >= LOCK_CNT) begin
              m_st = LOCKED; m_rdy = 1'b1; m_lock = lock_new; m_miss = 0;
            end
          end else begin
            m_cnt = 0;
          end
          m_prev = fval;
        end
        LOCKED: begin
          m_prev = fval;
          if (absd(fval, m_lock) > UNLOCK_TOL) begin
            m_cnt = 0;
            m_miss++;
            if (m_miss >= UNLOCK_CNT) begin
              m_st = ACQUIRE; m_rdy = 1'b0; m_miss = 0;
            end
          end else begin
            m_miss = 0;
            m_cnt  = sat255(m_cnt + 1);
`ifdef FREQ_LOCK_AVG_EN
            m_lock = lock_new;
`endif
          end
        end
      endcase
    end
    e.rdy   = m_rdy;
    e.flock = m_lock;
    e.cnt   = 8'(m_cnt);
    e.st    = m_st;
    exp_q.push_back(e);
    // Silence longer than the timeout after this edge: link declared lost.
    if (sw && (m_st == ACQUIRE || m_st == LOCKED) && gap > int'(TIMEOUT_CYC)) begin
      exp_lost_q.push_back(cyc + 4 + TIMEOUT_CYC);
      m_st = LOST; m_rdy = 1'b0; m_cnt = 0; m_miss = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One link rising edge carrying fval; next rising edge follows exactly gap cycles later.
  task automatic link_edge(input int gap, input freq_t fval, input logic sw);
    int hi;
    hi = gap / 2;
    @(negedge clk);
    model_edge(fval, sw, gap);
    f    = fval;
    link = 1'b1;
    repeat (3) @(negedge clk);
    swiptAlive = sw;
    repeat (hi - 3) @(negedge clk);
    link = 1'b0;
    repeat (gap - hi - 1) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero(tag);
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin : edge_monitor
    exp_t e;
    forever begin
      @(posedge link);
      repeat (3) @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL edge_expectation: got none expected one (cycle %0d)", cyc);
      end else begin
        e = exp_q[0];
        check("rdy_before", 32'(freq_rdy), 32'(e.rdy_b));
        check("state_before", 32'(state), 32'(e.st_b));
        @(negedge clk);
        e = exp_q.pop_front();
        check("freq_rdy", 32'(freq_rdy), 32'(e.rdy));
        check("f_lock", f_lock, e.flock);
        check("lock_cnt", 32'(lock_cnt), 32'(e.cnt));
        check("state", 32'(state), 32'(e.st));
      end
    end
  end

  initial begin : lost_monitor
    int unsigned exp_c;
    forever begin
      @(negedge clk);
      if (link_lost === 1'b1) begin
        if (exp_lost_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL link_lost_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_c = exp_lost_q.pop_front();
          check("link_lost_cycle", cyc, exp_c);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (200000) @(posedge clk);
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int    g;
    freq_t fv;
    logic  sw;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Clean 40 kHz reference: lock on the 5th edge.
    for (int i = 0; i < 6; i++) link_edge(2500, freq_t'(F0_HZ), 1'b1);

    // Single excursion tolerated, two consecutive force unlock, then reacquire.
    link_edge(30, freq_t'(F0_HZ + 100), 1'b1);
    link_edge(30, freq_t'(F0_HZ), 1'b1);
    link_edge(30, freq_t'(F0_HZ + 100), 1'b1);
    link_edge(30, freq_t'(F0_HZ + 100), 1'b1);
    for (int i = 0; i < 5; i++) link_edge(30, freq_t'(F0_HZ), 1'b1);

    // Gap of exactly the timeout limit survives; one cycle more declares link lost.
    link_edge(TIMEOUT_CYC, freq_t'(F0_HZ), 1'b1);
    link_edge(TIMEOUT_CYC + 1, freq_t'(F0_HZ), 1'b1);
    for (int i = 0; i < 5; i++) link_edge(30, freq_t'(F0_HZ), 1'b1);

    // Long in-tolerance run drives lock_cnt into saturation.
    for (int i = 0; i < 260; i++) begin
      fv = freq_t'(F0_HZ - 30 + $urandom_range(0, 60));
      link_edge(12, fv, 1'b1);
    end

    do_reset("mid_reset");
    link_edge(30, freq_t'(40000), 1'b1);
    link_edge(30, freq_t'(40010), 1'b1);
    link_edge(30, freq_t'(40050), 1'b1);
    link_edge(30, freq_t'(40055), 1'b1);
    link_edge(30, freq_t'(40060), 1'b1);
    link_edge(30, freq_t'(40062), 1'b1);
    link_edge(30, freq_t'(40064), 1'b1);

    do_reset("avg_reset");
    link_edge(30, freq_t'(40000), 1'b1);
    link_edge(30, freq_t'(40000), 1'b1);
    link_edge(30, freq_t'(40008), 1'b1);
    link_edge(30, freq_t'(40004), 1'b1);
    link_edge(30, freq_t'(40012), 1'b1);

    // swiptAlive drops on the same cycle an edge is consumed.
    do_reset("swipt_reset");
    link_edge(30, freq_t'(F0_HZ), 1'b1);
    link_edge(30, freq_t'(F0_HZ), 1'b1);
    link_edge(30, freq_t'(F0_HZ), 1'b0);
    link_edge(30, freq_t'(F0_HZ), 1'b0);
    for (int i = 0; i < 6; i++) link_edge(30, freq_t'(F0_HZ), 1'b1);

    // Extremes of the 32-bit difference.
    link_edge(30, 32'hFFFF_FFF0, 1'b1);
    link_edge(30, 32'hFFFF_FFFF, 1'b1);
    link_edge(30, 32'hFFFF_FFF0, 1'b1);
    link_edge(30, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 5; i++) link_edge(20, 32'h0000_0008, 1'b1);

    for (int i = 0; i < 200; i++) begin
      g  = $urandom_range(10, 60);
      fv = freq_t'(F0_HZ - 80 + $urandom_range(0, 160));
      sw = ($urandom_range(0, 15) != 0);
      link_edge(g, fv, sw);
    end

    repeat (20) @(negedge clk);
    check("edge_queue_drained", 32'(exp_q.size()), 32'd0);
    check("lost_queue_drained", 32'(exp_lost_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
